// File: rtl/alarm_pkg.sv
// Shared types, display geometry and helpers for the alarm display controller.
package alarm_pkg;

  localparam int DIGIT_W    = 7;
  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = DIGIT_W * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  typedef enum logic [1:0] {
    SRC_TIME  = 2'd0,
    SRC_MSG   = 2'd1,
    SRC_BLANK = 2'd2
  } seg_src_e;

  function automatic logic [SEG_W-1:0] blank_seg(input logic active_low);
    return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  // Width that holds 0..limit inclusive, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Saturating tick counter with synchronous clear; done flags a count held at LIMIT.
module tick_counter
  import alarm_pkg::*;
#(
  parameter int LIMIT = 2,
  localparam int CW   = cnt_width(LIMIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          done
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so a transition on a tick cycle consumes that tick.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q < LIM)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (count_q == LIM);

endmodule

// File: rtl/alarm_display_ctrl.sv
// Alarm sequencer for the 4-digit display: time readout, blinking message, buzzer,
// snooze and dismiss handling, with registered display and buzzer outputs.
module alarm_display_ctrl
  import alarm_pkg::*;
#(
  parameter int BLINK_TICKS    = 2,
  parameter int RING_TICKS     = 60,
  parameter int SNOOZE_TICKS   = 300,
  parameter int SNOOZE_MAX     = 3,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             alarm_fire,
  input  logic             snooze,
  input  logic             dismiss,
  input  logic [SEG_W-1:0] time_seg,
  input  logic [SEG_W-1:0] msg_seg,
  output logic [SEG_W-1:0] seg,
  output logic             buzz,
  output logic             alarm_active
);

  localparam int BW  = cnt_width(BLINK_TICKS);
  localparam int RW  = cnt_width(RING_TICKS);
  localparam int SW  = cnt_width(SNOOZE_TICKS);
  localparam int SCW = cnt_width(SNOOZE_MAX);

  localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [RW-1:0]  RING_LAST  = RW'(RING_TICKS - 1);
  localparam logic [SW-1:0]  SNZ_LAST   = SW'(SNOOZE_TICKS - 1);
  localparam logic [SCW-1:0] SNZ_MAX_C  = SCW'(SNOOZE_MAX);
  localparam logic [SEG_W-1:0] BLANK_WORD = blank_seg(1'(SEG_ACTIVE_LOW));

  alarm_state_e     state_q, state_d;
  logic             blank_q, blank_d;
  logic [SCW-1:0]   snz_cnt_q, snz_cnt_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             buzz_q, buzz_d;
  seg_src_e         seg_src;

  logic          enter_ring, go_snooze;
  logic          in_ring, in_snooze;
  logic [BW-1:0] blink_cnt;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_tmr_cnt;
  logic          blink_done, ring_done, snz_tmr_done;
  logic          blink_edge, ring_expire, snz_expire;

  assign in_ring   = (state_q == RING);
  assign in_snooze = (state_q == SNOOZE);

  // Expiry fires on the tick that completes the interval, so the state moves on that edge.
  assign blink_edge  = in_ring && ((tick && (blink_cnt == BLINK_LAST)) || blink_done);
  assign ring_expire = ring_done || (tick && (ring_cnt == RING_LAST));
  assign snz_expire  = snz_tmr_done || (tick && (snz_tmr_cnt == SNZ_LAST));

  tick_counter #(.LIMIT(BLINK_TICKS)) u_blink_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_ring || blink_edge),
    .en    (tick && in_ring),
    .count (blink_cnt),
    .done  (blink_done)
  );

  tick_counter #(.LIMIT(RING_TICKS)) u_ring_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (enter_ring),
    .en    (tick && in_ring),
    .count (ring_cnt),
    .done  (ring_done)
  );

  tick_counter #(.LIMIT(SNOOZE_TICKS)) u_snooze_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (go_snooze),
    .en    (tick && in_snooze),
    .count (snz_tmr_cnt),
    .done  (snz_tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    enter_ring = 1'b0;
    go_snooze  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alarm_fire) begin
          state_d    = RING;
          enter_ring = 1'b1;
        end
      end
      RING: begin
        if (dismiss) begin
          state_d = IDLE;
        end else if (snooze && (snz_cnt_q < SNZ_MAX_C)) begin
          state_d   = SNOOZE;
          go_snooze = 1'b1;
        end else if (ring_expire) begin
          state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (dismiss) begin
          state_d = IDLE;
        end else if (snz_expire || alarm_fire) begin
          state_d    = RING;
          enter_ring = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    seg_src = SRC_TIME;
    buzz_d  = 1'b0;
    if (in_ring) begin
      seg_src = blank_q ? SRC_BLANK : SRC_MSG;
      buzz_d  = !blank_q;
    end
  end

  // Blink phase and per-event snooze count.
  always_comb begin
    blank_d   = blank_q;
    snz_cnt_d = snz_cnt_q;
    if (enter_ring) begin
      blank_d = 1'b0;
    end else if (blink_edge) begin
      blank_d = !blank_q;
    end
    if (enter_ring && (state_q == IDLE)) begin
      snz_cnt_d = '0;
    end else if (go_snooze) begin
      snz_cnt_d = snz_cnt_q + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign seg_d[gi*DIGIT_W +: DIGIT_W] =
        (seg_src == SRC_MSG)   ? msg_seg[gi*DIGIT_W +: DIGIT_W]    :
        (seg_src == SRC_BLANK) ? BLANK_WORD[gi*DIGIT_W +: DIGIT_W] :
                                 time_seg[gi*DIGIT_W +: DIGIT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q   <= 1'b0;
      snz_cnt_q <= '0;
      seg_q     <= time_seg;
      buzz_q    <= 1'b0;
    end else begin
      blank_q   <= blank_d;
      snz_cnt_q <= snz_cnt_d;
      seg_q     <= seg_d;
      buzz_q    <= buzz_d;
    end
  end

  assign seg          = seg_q;
  assign buzz         = buzz_q;
  assign alarm_active = in_ring || in_snooze;

endmodule

// File: doc/alarm_display_ctrl.md
# alarm_display_ctrl

Sequences the shared 4-digit seven-segment display of the alarm clock between the normal time readout and the alarm message pattern ("UPUP"). On an alarm event it blinks the message, drives the buzzer enable, handles snooze and dismiss, and times out on its own. It sits between the time formatter, the message character generators and the display pins, and is the only driver of the display bus.

## Interface
- `BLINK_TICKS`, default 2: ticks per blink half-period (message shown, then blanked).
- `RING_TICKS`, default 60: ticks in RING before auto-timeout to IDLE.
- `SNOOZE_TICKS`, default 300: ticks spent in SNOOZE before re-ringing.
- `SNOOZE_MAX`, default 3: snoozes honoured per alarm event; further snooze pulses are ignored.
- `SEG_ACTIVE_LOW`, default 1: 1 means a segment is lit at 0, so the blank digit is all ones.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: single-cycle timebase strobe (1 Hz nominal).
- `alarm_fire` in 1: single-cycle pulse when alarm time matches.
- `snooze` in 1: debounced single-cycle button pulse.
- `dismiss` in 1: debounced single-cycle button pulse.
- `time_seg` in 28: time digits, digit0 = [6:0] … digit3 = [27:21].
- `msg_seg` in 28: message pattern, same packing.
- `seg` out 28: display bus, registered.
- `buzz` out 1: buzzer enable, registered.
- `alarm_active` out 1: high in RING or SNOOZE.

## Operation
- States:
  - IDLE: `seg` = `time_seg`, `buzz` = 0.
  - RING: `seg` alternates between `msg_seg` and blank every `BLINK_TICKS` ticks, starting with the message visible. `buzz` = 1 while the message is visible and 0 while blanked.
  - SNOOZE: `seg` = `time_seg`, `buzz` = 0.
- Transitions, evaluated on every clock:
  - IDLE, `alarm_fire` → RING. The ring counter, blink counter and snooze count are cleared.
  - RING, `dismiss` → IDLE.
  - RING, `snooze` with snooze count < `SNOOZE_MAX` → SNOOZE. Snooze count increments and the snooze counter is cleared.
  - RING, ring counter reaches `RING_TICKS` → IDLE.
  - SNOOZE, `dismiss` → IDLE.
  - SNOOZE, snooze counter reaches `SNOOZE_TICKS` → RING. Ring and blink counters are cleared; snooze count is kept.
  - SNOOZE, `alarm_fire` → RING immediately, with the same clears as above.
- In RING, `alarm_fire` is ignored and does not restart the timeout.
- Priority for simultaneous events: `dismiss` > `snooze` > timeout or `alarm_fire`. A state transition on the same cycle as `tick` consumes that tick; the tick does not also count in the new state.
- Counters advance only on cycles with `tick` = 1.
- Counter widths are `$clog2(param+1)`. Counters saturate at their limit and never wrap.
- `alarm_active` is a combinational decode of the state register.

## Timing
- Reset values: state IDLE, all counters 0, `seg` = `time_seg` registered on the next edge (blank is not driven), `buzz` = 0. Reset asserted mid-RING or mid-SNOOZE returns to IDLE on that edge.
- `seg` and `buzz` are registered, so they lag the state or input change by one cycle. `time_seg` changes appear on `seg` one cycle later.
- Event latency:
  - `alarm_fire` at edge N: state is RING after edge N, message is on `seg` after edge N+1.
  - `dismiss` at edge N: `buzz` = 0 and time is shown after edge N+1.
- Blink edges occur on the `tick` cycle that completes `BLINK_TICKS` ticks. The output toggles one cycle after that tick.

## Structure
- Shared package `alarm_pkg` holds:
  - the state enum (IDLE, RING, SNOOZE);
  - `DIGIT_W` = 7 and `NUM_DIGITS` = 4;
  - a function `blank_seg(active_low)` returning the 28-bit blank word.
- One sub-module, `tick_counter`, is used three times (blink, ring, snooze). Ports: clear, enable (tick), limit parameter, saturating count, done flag.
- The output mux and registers live in the top module.

## Test plan
- Reset mid-RING with `RING_TICKS`=4: assert `rst` for 1 cycle → state IDLE, `buzz`=0, `seg`=`time_seg` after the next edge.
- Fire, no buttons, `BLINK_TICKS`=2, `RING_TICKS`=8, one tick every 5 clocks → `seg` shows msg, blank, msg, blank (2 ticks each), `buzz` follows the message phases, IDLE after the 8th tick.
- Fire, snooze after 3 ticks, `SNOOZE_TICKS`=4 → SNOOZE showing time with `buzz`=0, back to RING on the 4th tick with the message visible.
- Snooze limit, `SNOOZE_MAX`=2: snooze three times → third pulse ignored, RING continues until timeout.
- `dismiss` and `snooze` in the same cycle during RING → IDLE, snooze count unchanged.
- `alarm_fire` during RING at tick 3 of 8 → no restart, timeout still on tick 8. `alarm_fire` during SNOOZE → RING on the next edge.
